// File: rtl/upsp_ac_bridge.sv
// Upsampler-side access-control endpoint: fetches the source frame into an input FIFO,
// feeds the core over valid/ready, and writes core results back through an output FIFO.

// First-word-fall-through FIFO; simultaneous push/pop is legal when full.
module upsp_ac_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [W-1:0]               i_dat,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dat,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_pop   = i_pop && !w_empty;
   assign w_push  = i_push && (!w_full || w_pop);
   assign o_dat   = r_mem[r_rp];
   assign o_cnt   = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_clr) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         // pointers wrap naturally because DEPTH is a power of two
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_mem[r_wp] <= i_dat;
   end
endmodule

module upsp_ac_bridge #(
   parameter int CRF_DATA_WIDTH  = 32,
   parameter int UPSP_DATA_WIDTH = 32,
   parameter int SRC_W           = 960,
   parameter int SRC_H           = 540,
   parameter int SCALE           = 4,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CRF_DATA_WIDTH-1:0]  UPSTR,
   input  logic [CRF_DATA_WIDTH-1:0]  UPENDR,
   output logic                       upsp_ac_rd,
   input  logic                       ac_upsp_rvalid,
   input  logic [UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
   input  logic                       ac_upsp_wready,
   output logic                       upsp_ac_wrt,
   output logic [UPSP_DATA_WIDTH-1:0] upsp_ac_wdata,
   output logic                       core_in_valid,
   input  logic                       core_in_ready,
   output logic [UPSP_DATA_WIDTH-1:0] core_in_data,
   input  logic                       core_out_valid,
   output logic                       core_out_ready,
   input  logic [UPSP_DATA_WIDTH-1:0] core_out_data,
   output logic                       busy,
   output logic                       done,
   output logic                       proto_err
);
   localparam int N_IN  = SRC_W * SRC_H;
   localparam int N_OUT = N_IN * SCALE * SCALE;
   localparam int IW    = $clog2(N_IN + 1);
   localparam int OW    = $clog2(N_OUT + 1);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int CW1   = CW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t        r_state;
   logic          r_st_q;
   logic [IW-1:0] r_rd_cnt;
   logic [OW-1:0] r_wr_cnt;
   logic [CW-1:0] r_outst;
   logic          r_proto_err;

   logic          w_start;
   logic          w_active;
   logic          w_abort;
   logic          w_clr;
   logic          w_rv_ok;
   logic          w_rv_spur;
   logic          w_in_pop;
   logic          w_out_push;
   logic          w_wr_xfer;
   logic [CW-1:0] w_in_cnt;
   logic [CW-1:0] w_out_cnt;
   logic          w_unused;

   assign w_unused = ^{UPSTR[CRF_DATA_WIDTH-1:1], UPENDR[CRF_DATA_WIDTH-1:1]};

   assign w_start  = UPSTR[0] && !r_st_q;
   assign w_active = (r_state != ST_IDLE);
   assign w_abort  = w_active && UPENDR[0];
   assign w_clr    = w_abort || ((r_state == ST_IDLE) && w_start);

   // credit rule: buffered plus in-flight words never exceed the input FIFO depth
   assign upsp_ac_rd = (r_state == ST_RUN) && !UPENDR[0] && (r_rd_cnt < IW'(N_IN)) &&
                       (({1'b0, w_in_cnt} + {1'b0, r_outst}) < CW1'(FIFO_DEPTH));

   assign w_rv_ok   = w_active && ac_upsp_rvalid && (r_outst != '0);
   assign w_rv_spur = w_active && ac_upsp_rvalid && (r_outst == '0);

   assign core_in_valid  = (w_in_cnt != '0);
   assign w_in_pop       = core_in_valid && core_in_ready;
   assign core_out_ready = (w_out_cnt != CW'(FIFO_DEPTH));
   assign w_out_push     = w_active && core_out_valid && core_out_ready;

   assign upsp_ac_wrt = w_active && (w_out_cnt != '0);
   assign w_wr_xfer   = upsp_ac_wrt && ac_upsp_wready;
   assign done        = (r_state == ST_DRAIN) && w_wr_xfer && !w_abort &&
                        (r_wr_cnt >= OW'(N_OUT - 1));

   assign busy      = w_active;
   assign proto_err = r_proto_err;

   upsp_ac_fifo #(.W(UPSP_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_push (w_rv_ok),
      .i_dat  (ac_upsp_rdata),
      .i_pop  (w_in_pop),
      .o_dat  (core_in_data),
      .o_cnt  (w_in_cnt)
   );

   upsp_ac_fifo #(.W(UPSP_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_push (w_out_push),
      .i_dat  (core_out_data),
      .i_pop  (w_wr_xfer),
      .o_dat  (upsp_ac_wdata),
      .o_cnt  (w_out_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_st_q      <= 1'b1;   // a start level held through reset must not look like an edge
         r_rd_cnt    <= '0;
         r_wr_cnt    <= '0;
         r_outst     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_st_q <= UPSTR[0];
         if (w_rv_spur) r_proto_err <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state     <= ST_RUN;
                  r_rd_cnt    <= '0;
                  r_wr_cnt    <= '0;
                  r_outst     <= '0;
                  r_proto_err <= 1'b0;
               end
            end
            default: begin
               if (w_abort) begin
                  r_state <= ST_IDLE;
                  r_outst <= '0;
               end else begin
                  if (upsp_ac_rd) r_rd_cnt <= r_rd_cnt + IW'(1);
                  r_outst <= r_outst + CW'(upsp_ac_rd) - CW'(w_rv_ok);
                  if (w_wr_xfer && (r_wr_cnt != OW'(N_OUT))) r_wr_cnt <= r_wr_cnt + OW'(1);
                  if ((r_state == ST_RUN) && (r_rd_cnt == IW'(N_IN)) && (r_outst == '0))
                     r_state <= ST_DRAIN;
                  if (done) r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_upsp_ac_bridge.sv
// Randomized bench for upsp_ac_bridge: AC and core models driven by $urandom,
// every output checked per cycle against a count-based reference of the frame.
module tb_upsp_ac_bridge;
   localparam int CW    = 32;
   localparam int DW    = 32;
   localparam int SW    = 4;
   localparam int SH    = 2;
   localparam int SC    = 2;
   localparam int FD    = 4;
   localparam int N_IN  = SW * SH;
   localparam int REP   = SC * SC;
   localparam int N_OUT = N_IN * REP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] UPSTR = '0;
   logic [CW-1:0] UPENDR = '0;
   logic          ac_upsp_rvalid = 1'b0;
   logic [DW-1:0] ac_upsp_rdata = '0;
   logic          ac_upsp_wready = 1'b0;
   logic          core_in_ready = 1'b0;
   logic          core_out_valid = 1'b0;
   logic [DW-1:0] core_out_data = '0;
   logic          upsp_ac_rd, upsp_ac_wrt, core_in_valid, core_out_ready;
   logic          busy, done, proto_err;
   logic [DW-1:0] upsp_ac_wdata, core_in_data;

   upsp_ac_bridge #(
      .CRF_DATA_WIDTH(CW), .UPSP_DATA_WIDTH(DW), .SRC_W(SW), .SRC_H(SH),
      .SCALE(SC), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .UPSTR(UPSTR), .UPENDR(UPENDR),
      .upsp_ac_rd(upsp_ac_rd), .ac_upsp_rvalid(ac_upsp_rvalid), .ac_upsp_rdata(ac_upsp_rdata),
      .ac_upsp_wready(ac_upsp_wready), .upsp_ac_wrt(upsp_ac_wrt), .upsp_ac_wdata(upsp_ac_wdata),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
      .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
      .core_out_data(core_out_data), .busy(busy), .done(done), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference state: frame source pixels and transaction counts
   logic [DW-1:0] src [N_IN];
   int            n_rd, n_rv, n_pop, n_push, n_wr, n_done;
   bit            frame_live, pe_m, prev_upstr;
   int            ac_due[$];
   logic [DW-1:0] ac_dat[$];
   logic [DW-1:0] core_q[$];
   bit            ov_acc = 1'b1;
   bit            prev_stall;
   logic [DW-1:0] prev_wdata;
   int            cyc = 0;
   int            lat_min, lat_max, inrdy_pct, ovld_pct, wrdy_pct;
   bit            inrdy_hold0, wrdy_hold0, spur, g_start, g_abort;

   task automatic clear_counts();
      n_rd = 0; n_rv = 0; n_pop = 0; n_push = 0; n_wr = 0; n_done = 0;
      core_q.delete();
      ov_acc = 1'b1;
   endtask

   task automatic new_frame();
      clear_counts();
      for (int i = 0; i < N_IN; i++) src[i] = $urandom;
   endtask

   task automatic knobs(input int lmin, input int lmax, input int irdy, input int ovld, input int wrdy);
      lat_min = lmin; lat_max = lmax; inrdy_pct = irdy; ovld_pct = ovld; wrdy_pct = wrdy;
      inrdy_hold0 = 1'b0; wrdy_hold0 = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_rd"}, upsp_ac_rd, 0);
      check_eq({tag, "_wrt"}, upsp_ac_wrt, 0);
      check_eq({tag, "_in_valid"}, core_in_valid, 0);
      check_eq({tag, "_out_ready"}, core_out_ready, 1);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_proto_err"}, proto_err, 0);
   endtask

   task automatic step();
      int outst, infifo, outfifo;
      bit start_now, wrote;
      @(negedge clk);
      cyc++;
      ac_upsp_rvalid = 1'b0;
      if (spur) begin
         ac_upsp_rvalid = 1'b1;
         ac_upsp_rdata  = $urandom;
      end else if (ac_due.size() > 0 && ac_due[0] <= cyc) begin
         ac_upsp_rvalid = 1'b1;
         ac_upsp_rdata  = ac_dat[0];
      end
      core_in_ready = inrdy_hold0 ? 1'b0 : ($urandom_range(99) < inrdy_pct);
      if (!(core_out_valid && !ov_acc)) begin
         core_out_valid = (core_q.size() > 0) && ($urandom_range(99) < ovld_pct);
         if (core_out_valid) core_out_data = core_q[0];
      end
      ac_upsp_wready = wrdy_hold0 ? 1'b0 : ($urandom_range(99) < wrdy_pct);
      UPSTR[0]  = g_start;
      UPENDR[0] = g_abort;
      #1;
      outst   = n_rd - n_rv;
      infifo  = n_rv - n_pop;
      outfifo = n_push - n_wr;
      start_now  = g_start && !prev_upstr && !frame_live;
      prev_upstr = g_start;
      check_eq("rd", upsp_ac_rd, frame_live && !g_abort && n_rd < N_IN && (outst + infifo) < FD);
      check_eq("busy", busy, frame_live);
      check_eq("proto_err", proto_err, pe_m);
      check_eq("in_valid", core_in_valid, infifo > 0);
      check_eq("out_ready", core_out_ready, outfifo < FD);
      check_eq("wrt", upsp_ac_wrt, frame_live && outfifo > 0);
      if (prev_stall) check_eq("wdata_hold", upsp_ac_wdata, prev_wdata);
      prev_stall = upsp_ac_wrt && !ac_upsp_wready && !g_abort;
      prev_wdata = upsp_ac_wdata;
      ov_acc = core_out_valid && core_out_ready;

      if (upsp_ac_rd) begin
         ac_due.push_back(cyc + $urandom_range(lat_max, lat_min));
         ac_dat.push_back(n_rd < N_IN ? src[n_rd] : '0);
         n_rd++;
      end
      if (ac_upsp_rvalid) begin
         if (!spur) begin
            void'(ac_due.pop_front());
            void'(ac_dat.pop_front());
         end
         if (frame_live) begin
            if (outst == 0) pe_m = 1'b1;
            else n_rv++;
         end
      end
      if (core_in_valid && core_in_ready) begin
         if (n_pop < N_IN) check_eq("core_in_data", core_in_data, src[n_pop]);
         n_pop++;
         for (int k = 0; k < REP; k++) core_q.push_back(core_in_data);
      end
      if (ov_acc) begin
         void'(core_q.pop_front());
         if (frame_live) n_push++;
      end
      wrote = upsp_ac_wrt && ac_upsp_wready;
      if (wrote) begin
         if (n_wr < N_OUT) check_eq("wdata", upsp_ac_wdata, src[n_wr / REP]);
         n_wr++;
         check_eq("done", done, (n_wr == N_OUT) && !g_abort);
      end else begin
         check_eq("done_quiet", done, 0);
      end
      if (done) n_done++;

      if (frame_live && g_abort) begin
         frame_live = 1'b0;
         n_rd = 0; n_rv = 0; n_pop = 0; n_push = 0; n_wr = 0;
         core_q.delete();
         ov_acc = 1'b1;
      end else if (frame_live && wrote && n_wr == N_OUT) begin
         frame_live = 1'b0;
      end
      if (start_now) begin
         frame_live = 1'b1;
         pe_m = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (frame_live && n < budget) begin
         step();
         n++;
      end
      check_eq({tag, "_timeout"}, frame_live, 0);
      check_eq({tag, "_rd_cnt"}, n_rd, N_IN);
      check_eq({tag, "_wr_cnt"}, n_wr, N_OUT);
      check_eq({tag, "_done_cnt"}, n_done, 1);
      step();
      check_eq({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic start_frame();
      new_frame();
      g_start = 1'b1;
      step();
      g_start = 1'b0;
   endtask

   initial begin
      int n;
      knobs(1, 1, 100, 100, 100);
      spur = 0; g_start = 0; g_abort = 0; prev_upstr = 0;
      frame_live = 0; pe_m = 0; prev_stall = 0;
      clear_counts();
      repeat (3) @(negedge clk);
      #1;
      check_reset("reset");
      rst_n = 1'b1;
      repeat (3) step();

      // basic frame, one-cycle AC latency, core always ready
      start_frame();
      wait_done("basic", 2000);

      // read backpressure: slow AC, core refuses pixels
      knobs(6, 6, 60, 100, 100);
      inrdy_hold0 = 1'b1;
      start_frame();
      repeat (30) step();
      check_eq("bp_rd_stop", n_rd, FD);
      check_eq("bp_buffered", n_rv - n_pop, FD);
      inrdy_hold0 = 1'b0;
      wait_done("bp", 2000);

      // write stall: AC refuses writes for 20 cycles
      knobs(1, 1, 100, 100, 100);
      wrdy_hold0 = 1'b1;
      start_frame();
      repeat (20) step();
      check_eq("ws_out_full", core_out_ready, 0);
      check_eq("ws_out_cnt", n_push - n_wr, FD);
      wrdy_hold0 = 1'b0;
      wait_done("ws", 2000);

      // abort after three reads, then a clean frame
      knobs(1, 1, 100, 100, 100);
      start_frame();
      n = 0;
      while (n_rd < 3 && n < 100) begin
         step();
         n++;
      end
      check_eq("ab_reads", n_rd, 3);
      g_abort = 1'b1;
      step();
      g_abort = 1'b0;
      repeat (8) step();
      check_eq("ab_idle", busy, 0);
      check_eq("ab_no_done", n_done, 0);
      check_eq("ab_no_perr", proto_err, 0);
      start_frame();
      wait_done("ab_clean", 2000);

      // spurious read data in the first RUN cycle
      knobs(1, 3, 80, 80, 80);
      start_frame();
      spur = 1'b1;
      step();
      spur = 1'b0;
      wait_done("sp", 2000);
      check_eq("sp_sticky", proto_err, 1);
      start_frame();
      step();
      check_eq("sp_cleared", proto_err, 0);
      wait_done("sp_next", 2000);

      // randomized frames
      for (int f = 0; f < 4; f++) begin
         knobs(1, $urandom_range(5, 1), $urandom_range(100, 30), $urandom_range(100, 30),
               $urandom_range(100, 30));
         start_frame();
         wait_done("rand", 3000);
      end

      // async reset mid-DRAIN with UPSTR held high through reset
      knobs(1, 1, 100, 100, 10);
      start_frame();
      n = 0;
      while (n_rv < N_IN && n < 500) begin
         step();
         n++;
      end
      step();
      step();
      check_eq("rs_in_drain", busy && (n_wr < N_OUT), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      UPSTR[0] = 1'b1;
      ac_upsp_rvalid = 1'b0;
      core_out_valid = 1'b0;
      #1;
      check_reset("rs_async");
      frame_live = 0; pe_m = 0; prev_stall = 0; prev_upstr = 1;
      clear_counts();
      ac_due.delete();
      ac_dat.delete();
      g_start = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) step();
      check_eq("rs_no_start", busy, 0);
      g_start = 1'b0;
      step();
      knobs(1, 2, 100, 100, 100);
      start_frame();
      wait_done("rs_after", 2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
